prog_loader: RTL
================

Name: prog_loader

Overview:
Upstream boot stage for the 4-bit CPU. It receives a length-prefixed, checksummed instruction byte stream over a valid/ready interface and writes it into the 16 x 8-bit instruction memory write port. It holds the CPU in reset until a load completes with a good checksum, then releases it.

Parameters:
DEPTH, 16, number of instruction memory words; also the maximum load length.
ADDR_W, 4, instruction memory address width; must satisfy 2^ADDR_W >= DEPTH.
DATA_W, 8, instruction word width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low; 0 = reset asserted.
start  input  1  level sampled each cycle; honoured only in IDLE, DONE or ERROR.
in_valid  input  1  source has a byte on in_data.
in_data  input  DATA_W  stream byte.
in_ready  output  1  loader accepts a byte; a transfer occurs on a cycle where in_valid=1 and in_ready=1.
im_we  output  1  instruction memory write strobe.
im_addr  output  ADDR_W  instruction memory write address.
im_wdata  output  DATA_W  instruction memory write data.
cpu_hold  output  1  active-high reset to the CPU core; 1 = CPU held.
busy  output  1  load in progress (HEADER, LOAD or CHECK).
done  output  1  last load succeeded.
err  output  1  last load failed.
loaded_len  output  ADDR_W+1  length of the last successful load.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - cpu_hold=1; busy=0, done=0, err=0, loaded_len=0.
  - Internal addr, len and xor_acc are cleared.
  - Memory contents are not touched.
- Stream format: header byte N (1..DEPTH), then N instruction bytes, then one checksum byte C.
  - C must equal the XOR of N and all N instruction bytes.
- Output timing:
  - in_ready is decoded from the registered state only; no combinational path from in_valid.
  - im_we = in_valid & in_ready & (state==LOAD).
  - im_addr = addr; im_wdata = in_data.
  - The write takes effect on the same rising edge as the transfer (zero latency).
  - cpu_hold, busy, done, err and loaded_len are registered.
- State machine:
  - IDLE:
    - in_ready=0, cpu_hold=1.
    - start=1: go to HEADER; busy=1, done=0, err=0.
  - HEADER:
    - in_ready=1.
    - On transfer with N==0 or N>DEPTH: go to ERROR.
    - Otherwise: len<=N, xor_acc<=N, addr<=0, go to LOAD.
  - LOAD:
    - in_ready=1.
    - On transfer: write in_data to addr, xor_acc ^= in_data.
    - If addr==len-1: go to CHECK. Otherwise addr<=addr+1.
    - addr never wraps, because len<=DEPTH.
  - CHECK:
    - in_ready=1.
    - On transfer with in_data==xor_acc: go to DONE; done=1, busy=0, cpu_hold=0, loaded_len<=len.
    - On transfer with a mismatch: go to ERROR.
  - DONE:
    - in_ready=0, cpu_hold=0.
    - start=1: go to HEADER; cpu_hold=1, done=0, busy=1.
  - ERROR:
    - err=1, busy=0, cpu_hold=1, in_ready=0.
    - start=1: go to HEADER; err=0, busy=1.
- cpu_hold rises and falls on the same edge as the state change.
  - The CPU PC therefore restarts at 0 on the first cycle after release.
- Boundary rules:
  - start while busy=1 is ignored, including a start in the same cycle as the checksum transfer.
  - in_valid=1 while in_ready=0 is ignored; nothing is consumed or written.
  - in_valid gaps stall the FSM with no state change.
  - A failed load leaves partially written memory; cpu_hold stays 1.
  - Async reset mid-load aborts immediately: in_ready and im_we drop with no clock edge.
  - Memory keeps any bytes already written.

Test Plan:
1. Reset: hold reset=0 with in_valid=1 -> cpu_hold=1, in_ready=0, im_we=0, busy/done/err=0, loaded_len=0. Release reset with start=0 -> state stays IDLE.
2. Good load:
   - Stimulus: start pulse, then bytes 03, 5B, 1A, C4, 86 (86 = 03^5B^1A^C4).
   - Required: im_we on three transfers with addr 0/1/2 and data 5B/1A/C4.
   - After the 86 transfer edge: done=1, cpu_hold=0, loaded_len=3, in_ready=0.
3. Bad checksum: same stream ending in 87 -> err=1, cpu_hold=1, done=0. A following start, then 01, FF, FE -> done=1, err=0.
4. Bad header:
   - Header 11 (hex) -> ERROR after one transfer, no im_we.
   - Header 00 -> ERROR, no im_we.
5. Full 16-word load with random in_valid gaps and start toggled mid-load:
   - Writes addr 0..15 in order with no wrap; start is ignored.
   - A correct checksum gives loaded_len=16, done=1.
6. Async reset mid-LOAD after 2 data bytes:
   - Outputs drop without a clock edge: in_ready=0, cpu_hold=1, busy=0.
   - A subsequent start and a full good stream load correctly.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte stream channel into the program loader: valid/ready handshake with one data byte.
// The source drives valid/data; the loader drives ready.
interface prog_loader_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader for the 4-bit CPU: takes a length-prefixed, XOR-checksummed byte stream,
// writes it into instruction memory and releases the CPU only after a good checksum.
//
// state  | meaning
// IDLE   | after reset, waiting for start; CPU held
// HEADER | waiting for length byte N
// LOAD   | writing N instruction bytes to addr 0..N-1
// CHECK  | waiting for checksum byte
// DONE   | last load good; CPU running
// ERROR  | last load bad (length or checksum); CPU held
module prog_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      s,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   loaded_len
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HEADER = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;

  localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(DEPTH);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] xor_acc;

  logic xfer;
  logic hdr_bad;
  logic last_byte;

  // ready is a pure state decode so an async reset drops it without a clock edge
  assign s.in_ready = (state == HEADER) || (state == LOAD) || (state == CHECK);
  assign xfer       = s.in_valid & s.in_ready;

  assign im_we    = xfer & (state == LOAD);
  assign im_addr  = addr;
  assign im_wdata = s.in_data;

  assign hdr_bad   = (s.in_data == '0) || (s.in_data > MAX_LEN);
  assign last_byte = ({1'b0, addr} == (len - (ADDR_W+1)'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      len        <= '0;
      xor_acc    <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      loaded_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= HEADER;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
        HEADER: begin
          if (xfer) begin
            if (hdr_bad) begin
              state <= ERROR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state   <= LOAD;
              len     <= s.in_data[ADDR_W:0];
              xor_acc <= s.in_data;
              addr    <= '0;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            xor_acc <= xor_acc ^ s.in_data;
            // addr stops at len-1 so it never wraps past the last word
            if (last_byte) begin
              state <= CHECK;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            busy <= 1'b0;
            if (s.in_data == xor_acc) begin
              state      <= DONE;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
              loaded_len <= len;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state    <= HEADER;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ERROR: begin
          if (start) begin
            state <= HEADER;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cpu_hold <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
